ni_flit_tx: RTL
===============

Name: ni_flit_tx

Overview:
- Network-interface transmitter: the injection end of a router input port.
- Accepts flits from a local core, buffers them per virtual channel (VC), and drives IDATA_x/IVALID_x/IVCH_x of one router port. Its outputs are ODATA/OVALID/OVCH here.
- Consumes the router's per-VC ACK/RDY/LCK return signals to do credit-based flow control, wormhole packet ordering and round-robin VC interleaving.

Parameters:
- FIFO_DEPTH, 4, flits buffered per VC on the core side (power of 2, ≥2)
- CREDITS, 4, router input-buffer depth per VC; initial and maximum credit count

Ports:
- clk  in  1  clock
- RST  in  1  reset, asynchronous, active-high
- TX_DATA  in  35  flit from core; [34:32] type: 001 head, 010 body, 011 tail, 100 head+tail; head [3:0] = {dst_y[1:0], dst_x[1:0]}
- TX_VALID  in  1  core flit valid
- TX_VCH  in  1  target VC of TX_DATA
- TX_READY  out  1  FIFO[TX_VCH] not full
- ODATA  out  35  flit to router
- OVALID  out  1  flit valid to router
- OVCH  out  1  VC of ODATA
- IACK  in  2  per-VC credit return pulse, one flit freed
- IRDY  in  2  per-VC router ready
- ILCK  in  2  per-VC router lock, previous packet still holds the VC
- CREDIT_ERR  out  1  sticky, ACK received with credit counter already at CREDITS

Behaviour:
- Reset state (async, while RST=1):
  - ODATA=0, OVALID=0, OVCH=0, CREDIT_ERR=0.
  - Both FIFOs empty.
  - credit[0]=credit[1]=CREDITS.
  - rr_ptr=0; both VC states IDLE.
- Core write:
  - Occurs when TX_VALID && TX_READY.
  - TX_READY is combinational: !full[TX_VCH]. It does not depend on a same-cycle pop.
  - TX_DATA is pushed into FIFO[TX_VCH]. Flit type is not checked on write.
- Per-VC state machine:
  - IDLE -> ACTIVE when a head (001) is sent.
  - ACTIVE -> IDLE when a tail (011) is sent.
  - A head+tail (100) send leaves the VC in IDLE.
- Eligibility of VC v in a given cycle. All of the following must hold:
  - FIFO[v] non-empty.
  - credit[v] > 0.
  - IRDY[v] = 1.
  - In IDLE: front flit is type 001 or 100, and ILCK[v] = 0.
  - In ACTIVE: front flit is type 010 or 011; ILCK is ignored.
- Protocol violations:
  - An IDLE VC with a body/tail at its front, or an ACTIVE VC with a head at its front, is stalled permanently.
  - Verification treats this as a protocol violation. No recovery short of reset.
- Arbitration:
  - At most one flit sent per cycle.
  - If both VCs are eligible, send VC rr_ptr; otherwise send the single eligible VC.
  - After any send on VC v, rr_ptr <= ~v.
- Send (registered, 1-cycle latency):
  - Next edge: ODATA <= front flit, OVCH <= v, OVALID <= 1; pop FIFO[v]; credit[v] decrements.
  - With no send, OVALID <= 0. ODATA/OVCH hold their last values.
- Credits:
  - IACK[v] pulse increments credit[v].
  - Send and IACK on the same VC in the same cycle: credit unchanged.
  - IACK[v] while credit[v] = CREDITS (and no same-cycle send on v): credit stays at CREDITS, CREDIT_ERR <= 1 until reset.
  - Counter width is clog2(CREDITS+1).
  - credit[v] = 0 blocks VC v only; the other VC proceeds.
- FIFO pointers: wrap modulo FIFO_DEPTH. Full and empty are distinguished by an extra pointer bit.
- Simultaneous push and pop on the same VC: both take effect; occupancy is unchanged.
- Reset mid-packet: all state returns to reset values immediately. Queued flits are discarded and credits are restored to CREDITS.

Test Plan:
- Single flit: reset, push head+tail 0x4_0000_0005 on VC0 with IRDY=11, ILCK=00 -> ODATA=0x400000005, OVALID=1, OVCH=0 exactly one cycle after the push cycle; credit[0]=3.
- Credit exhaustion: push 6-flit packet (head, 4 body, tail) on VC1, CREDITS=4, no IACK -> exactly 4 flits sent, then OVALID=0. Pulse IACK[1] twice -> remaining 2 flits sent; VC1 returns to IDLE.
- Interleave: 3-flit packets queued on both VCs, all enables high -> OVCH sequence 0,1,0,1,0,1 on consecutive cycles with OVALID continuously 1.
- Lock: ILCK[0]=1 with head queued on VC0 -> no VC0 send. Release ILCK[0] -> head sent next cycle. Raising ILCK[0] mid-packet does not stall its body/tail.
- Boundaries: fill FIFO0 with 4 flits while IRDY=00 -> TX_READY=0 for VC0, TX_READY=1 for VC1. IACK[0] pulse with credit[0]=4 -> CREDIT_ERR=1, credit[0] stays 4.
- Reset mid-operation: assert RST during the body phase of a VC0 packet -> OVALID=0 asynchronously. After release, TX_READY=1, a new head on VC0 is accepted and sent, credit[0]=3.

Source files
------------

// File: rtl/ni_flit_tx.sv
// Router-port injector: per-VC flit FIFOs, credit flow control, wormhole ordering, round-robin VC interleave.
// Send latency 1 cycle after a flit is at a FIFO front; TX_READY drops when the target FIFO is full.

module ni_flit_tx_fifo #(
    parameter int W     = 35,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    // The extra MSB separates full (MSBs differ) from empty (pointers equal).
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;
    end
endmodule

module ni_flit_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int CREDITS    = 4
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [34:0] TX_DATA,
    input  logic        TX_VALID,
    input  logic        TX_VCH,
    output logic        TX_READY,
    output logic [34:0] ODATA,
    output logic        OVALID,
    output logic        OVCH,
    input  logic [1:0]  IACK,
    input  logic [1:0]  IRDY,
    input  logic [1:0]  ILCK,
    output logic        CREDIT_ERR
);
    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

    localparam logic [2:0] T_HEAD = 3'b001;
    localparam logic [2:0] T_BODY = 3'b010;
    localparam logic [2:0] T_TAIL = 3'b011;
    localparam logic [2:0] T_HT   = 3'b100;

    typedef struct packed {
        logic [2:0]  ftype;
        logic [31:0] payload;
    } flit_t;

    typedef enum logic {IDLE, ACTIVE} vc_state_t;

    vc_state_t       state     [2];
    vc_state_t       state_nxt [2];
    logic [CW-1:0]   credit    [2];
    flit_t           front     [2];
    logic [1:0]      full;
    logic [1:0]      empty;
    logic [1:0]      push;
    logic [1:0]      pop;
    logic [1:0]      elig;
    logic            send;
    logic            send_vc;
    logic            rr_ptr;

    assign TX_READY = !full[TX_VCH];

    for (genvar g = 0; g < 2; g++) begin : g_vc
        ni_flit_tx_fifo #(.W(35), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (RST),
            .push  (push[g]),
            .wdata (TX_DATA),
            .pop   (pop[g]),
            .rdata (front[g]),
            .full  (full[g]),
            .empty (empty[g])
        );
    end

    // A VC whose front flit does not fit its packet state never becomes eligible.
    always_comb begin
        push = '0;
        elig = '0;
        for (int v = 0; v < 2; v++) begin
            push[v] = TX_VALID && !full[v] && (TX_VCH == v[0]);
            elig[v] = !empty[v] && (credit[v] != '0) && IRDY[v] &&
                      ((state[v] == IDLE)
                          ? (((front[v].ftype == T_HEAD) || (front[v].ftype == T_HT)) && !ILCK[v])
                          : ((front[v].ftype == T_BODY) || (front[v].ftype == T_TAIL)));
        end
    end

    always_comb begin
        send    = |elig;
        send_vc = (elig[0] && elig[1]) ? rr_ptr : elig[1];
        pop     = '0;
        pop[send_vc] = send;
    end

    always_comb begin
        for (int v = 0; v < 2; v++) begin
            state_nxt[v] = state[v];
            if (pop[v]) begin
                case (front[v].ftype)
                    T_HEAD:  state_nxt[v] = ACTIVE;
                    T_TAIL:  state_nxt[v] = IDLE;
                    default: state_nxt[v] = state[v];
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state[0] <= IDLE;
            state[1] <= IDLE;
        end else begin
            state[0] <= state_nxt[0];
            state[1] <= state_nxt[1];
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            credit[0]  <= CRED_MAX;
            credit[1]  <= CRED_MAX;
            CREDIT_ERR <= 1'b0;
        end else begin
            for (int v = 0; v < 2; v++) begin
                if (pop[v] && !IACK[v]) begin
                    credit[v] <= credit[v] - CW'(1);
                end else if (!pop[v] && IACK[v]) begin
                    if (credit[v] == CRED_MAX) CREDIT_ERR <= 1'b1;
                    else                       credit[v] <= credit[v] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            ODATA  <= '0;
            OVALID <= 1'b0;
            OVCH   <= 1'b0;
            rr_ptr <= 1'b0;
        end else begin
            OVALID <= send;
            if (send) begin
                ODATA  <= front[send_vc];
                OVCH   <= send_vc;
                rr_ptr <= ~send_vc;
            end
        end
    end
endmodule
